// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// led_ctrl_pkg : shared state encodings and output polarities
// Rev 1.0
// ------------------------------------------------------------------
package led_ctrl_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    SHIFT_L = 2'b00,
    SHIFT_R = 2'b01,
    FLASH   = 2'b10
  } state_e;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;
  localparam logic FUNC_SHIFT  = 1'b0;
  localparam logic FUNC_FLASH  = 1'b1;

  // Bits needed to hold 0 .. max_count-1, never less than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

  function automatic state_e next_state(input state_e s);
    case (s)
      SHIFT_L: return SHIFT_R;
      SHIFT_R: return FLASH;
      default: return SHIFT_L;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ------------------------------------------------------------------
// btn_debounce : 2-flop synchronizer, level debounce, press pulse
// Rev 1.0
// ------------------------------------------------------------------
module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any sample agreeing with the current level restarts the run.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/led_mode_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// led_mode_ctrl : LED display mode FSM, button and auto-cycle advance
// Rev 1.0
// ------------------------------------------------------------------
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DWELL_TICKS     = 8
) (
  input  logic              CLK_5_MHZ,
  input  logic              reset,
  input  logic              tick,
  input  logic              btn_next,
  input  logic              auto_en,
  output logic              shift_sel,
  output logic              func_sel,
  output logic              sub_reset,
  output logic [MODE_W-1:0] mode
);

  localparam int            DW         = cnt_width(DWELL_TICKS);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

  logic          btn_press;
  logic          unused_btn_level;
  logic          dwell_expiry;
  logic          advance;

  state_e        state_q,     state_d;
  logic          shift_sel_q, shift_sel_d;
  logic          func_sel_q,  func_sel_d;
  logic          sub_reset_q, sub_reset_d;
  logic [DW-1:0] dwell_q,     dwell_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (CLK_5_MHZ),
    .rst     (reset),
    .btn_raw (btn_next),
    .level   (unused_btn_level),
    .press   (btn_press)
  );

  always_comb begin
    dwell_expiry = auto_en && tick && (dwell_q == DWELL_LAST);
    // A press and an expiry in the same cycle collapse into one request.
    advance      = btn_press || dwell_expiry;

    state_d = state_q;
    case (state_q)
      SHIFT_L, SHIFT_R, FLASH: if (advance) state_d = next_state(state_q);
      default:                 state_d = SHIFT_L;
    endcase

    shift_sel_d = (state_d == SHIFT_R) ? SHIFT_RIGHT : SHIFT_LEFT;
    func_sel_d  = (state_d == FLASH)   ? FUNC_FLASH  : FUNC_SHIFT;

    dwell_d = dwell_q;
    if (!auto_en || advance) begin
      dwell_d = '0;
    end else if (tick) begin
      dwell_d = dwell_q + DW'(1);
    end

    // Held until a tick has been seen, so the slow domain always samples it.
    sub_reset_d = sub_reset_q;
    if (advance) begin
      sub_reset_d = 1'b1;
    end else if (tick) begin
      sub_reset_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_5_MHZ or posedge reset) begin
    if (reset) begin
      state_q     <= SHIFT_L;
      shift_sel_q <= SHIFT_LEFT;
      func_sel_q  <= FUNC_SHIFT;
      sub_reset_q <= 1'b1;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      shift_sel_q <= shift_sel_d;
      func_sel_q  <= func_sel_d;
      sub_reset_q <= sub_reset_d;
      dwell_q     <= dwell_d;
    end
  end

  assign shift_sel = shift_sel_q;
  assign func_sel  = func_sel_q;
  assign sub_reset = sub_reset_q;
  assign mode      = state_q;

endmodule
`default_nettype wire

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, is the number of consecutive stable clock samples needed to accept a button level (10 ms at 5 MHz).
REQ-002 Parameter DWELL_TICKS, default 8, is the number of tick pulses per mode in auto-cycle (4 s at 2 Hz).
REQ-003 The block has one clock; reset is asynchronous and active-high.
REQ-004 Port CLK_5_MHZ, input, 1 bit: the single clock for all state.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port tick, input, 1 bit: one-cycle enable pulse, synchronous to CLK_5_MHZ, at the display rate (2 Hz).
REQ-007 Port btn_next, input, 1 bit: raw, asynchronous, bouncing pushbutton; 1 = pressed.
REQ-008 Port auto_en, input, 1 bit: switch; 1 = auto-cycle modes.
REQ-009 Port shift_sel, output, 1 bit: shifter direction; 0 = left, 1 = right.
REQ-010 Port func_sel, output, 1 bit: display mux select; 0 = shift output, 1 = flash output.
REQ-011 Port sub_reset, output, 1 bit: active-high reset to the shift and flash blocks.
REQ-012 Port mode, output, 2 bits: current state encoding, for status display.

Function
REQ-013 btn_next shall pass through a 2-flop synchronizer before any other use.
REQ-014 The debounced level shall change only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from it; any sample equal to the current level clears the count.
REQ-015 A 0->1 transition of the debounced level shall produce a one-cycle press pulse; release shall produce nothing.
REQ-016 The FSM shall have states SHIFT_L=2'b00, SHIFT_R=2'b01 and FLASH=2'b10; 2'b11 is illegal and shall return to SHIFT_L on the next cycle.
REQ-017 The state advance order shall be SHIFT_L -> SHIFT_R -> FLASH -> SHIFT_L (wrap).
REQ-018 Output decode, registered: SHIFT_L gives shift_sel=0, func_sel=0; SHIFT_R gives 1,0; FLASH gives 0,1. mode equals the state.
REQ-019 The dwell counter shall increment on each tick while auto_en=1, and shall be held at 0 while auto_en=0.
REQ-020 An advance request shall occur on a press pulse, or when the dwell counter reaches DWELL_TICKS-1 and tick=1.
REQ-021 A press pulse and dwell expiry in the same cycle shall produce exactly one advance.
REQ-022 Latency: an advance request in cycle N shall update state, shift_sel, func_sel and mode at edge N+1.
REQ-023 Every advance shall clear the dwell counter to 0.
REQ-024 sub_reset shall assert at edge N+1 after an advance.
REQ-025 sub_reset shall remain asserted through the first cycle with tick=1 after that edge, and deassert on the following edge; this guarantees the 2 Hz domain samples it.
REQ-026 An advance while sub_reset is high shall restart the tick-wait, keeping sub_reset high.
REQ-027 auto_en falling mid-dwell shall zero the counter with no advance; auto_en rising shall start counting from 0.
REQ-028 A press held longer than debounce shall yield one advance only; held presses shall not repeat.

Reset
REQ-029 While reset=1: state=SHIFT_L, shift_sel=0, func_sel=0, mode=0, sub_reset=1, all counters=0, synchronizer and debounced level=0.
REQ-030 After reset deasserts, sub_reset shall stay 1 until the edge following the first tick.
REQ-031 Reset asserted mid-operation shall abort any debounce or dwell count immediately.

Structure
REQ-032 Package led_ctrl_pkg shall hold the state encodings (SHIFT_L, SHIFT_R, FLASH), the shift_sel/func_sel polarity constants and the mode width.
REQ-033 The synchronizer and debounce logic shall be a sub-module btn_debounce (parameter DEBOUNCE_CYCLES; outputs level and press pulse); all remaining logic stays in led_mode_ctrl.
REQ-034 Counter widths shall be derived from the parameters by $clog2, with no overflow at the maximum count.

Verification (bench with DEBOUNCE_CYCLES=4, DWELL_TICKS=3, tick every 10 cycles)
REQ-035 Reset, then 10 cycles idle -> mode=0, shift_sel=0, func_sel=0; sub_reset=1 until the edge after the first tick, then 0.
REQ-036 btn_next toggles every 2 cycles for 20 cycles, then stays 0 -> no advance, mode stays 0.
REQ-037 btn_next=1 for 30 cycles, then 0 -> exactly one advance; mode=1, shift_sel=1, func_sel=0; sub_reset high from the advance edge through the next tick.
REQ-038 auto_en=1, no press, 9 ticks -> mode sequence 0->1->2->0, one advance per 3 ticks, wrap from FLASH to SHIFT_L verified.
REQ-039 With auto_en=1, a press pulse forced coincident with the 3rd tick -> a single advance (mode +1, not +2) and the dwell counter restarts at 0.
REQ-040 In mode=2, assert reset for 3 cycles mid-debounce -> mode=0 and sub_reset=1 immediately, with no spurious advance after release.
